// File: rtl/arbiter_2req_pkg.sv
// Shared state encoding and sizing helper for the two-requester arbiter.
package arbiter_2req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10
    } state_t;

    // Counter width: clog2(limit+1), never narrower than one bit.
    function automatic int unsigned hold_cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Counts contended grant cycles; o_limit flags the cycle that completes LIMIT of them.
module arb_hold_counter
    import arbiter_2req_pkg::*;
#(
    parameter int unsigned LIMIT = 0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clear,
    output logic o_limit
);

    localparam int unsigned CW = hold_cnt_width(LIMIT);
    localparam logic [CW-1:0] LAST = CW'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (LIMIT != 0)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The current contended cycle is the LIMIT-th one, so the holder leaves at this edge.
    assign o_limit = (LIMIT != 0) && i_en && (r_count == LAST);

endmodule

// File: rtl/arbiter_2req.sv
// Two-agent grant FSM with registered, mutually exclusive grants and optional hold limit.
// ARB_ROUND_ROBIN_EN: IDLE ties go to the agent not granted last instead of agent 0.
module arbiter_2req
    import arbiter_2req_pkg::*;
#(
    parameter int unsigned HOLD_LIMIT = 0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_req_0,
    input  logic i_req_1,
    output logic o_gnt_0,
    output logic o_gnt_1
);

    state_t r_state;
    logic   r_gnt_0;
    logic   r_gnt_1;
    logic   r_favour;
    logic   r_favour_1;
`ifdef ARB_ROUND_ROBIN_EN
    logic   r_last_1;
`endif

    logic w_other_req;
    logic w_hold_en;
    logic w_hold_clear;
    logic w_limit;
    logic w_leave;
    logic w_sel_0;
    logic w_sel_1;

    assign w_other_req = (r_state == ST_GNT0) ? i_req_1 :
                         (r_state == ST_GNT1) ? i_req_0 : 1'b0;
    assign w_hold_en   = (r_state != ST_IDLE) && w_other_req;
    assign w_leave     = ((r_state == ST_GNT0) && (!i_req_0 || w_limit)) ||
                         ((r_state == ST_GNT1) && (!i_req_1 || w_limit));
    assign w_hold_clear = (r_state == ST_IDLE) || !w_other_req || w_leave;

    arb_hold_counter #(
        .LIMIT (HOLD_LIMIT)
    ) u_hold (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_en    (w_hold_en),
        .i_clear (w_hold_clear),
        .o_limit (w_limit)
    );

    // IDLE arbitration: a pending favour from a forced release beats the tie rule.
    always_comb begin
        w_sel_0 = 1'b0;
        w_sel_1 = 1'b0;
        if (r_favour && r_favour_1 && i_req_1) begin
            w_sel_1 = 1'b1;
        end else if (r_favour && !r_favour_1 && i_req_0) begin
            w_sel_0 = 1'b1;
        end else if (i_req_0 && i_req_1) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_sel_0 = r_last_1;
            w_sel_1 = !r_last_1;
`else
            w_sel_0 = 1'b1;
`endif
        end else if (i_req_0) begin
            w_sel_0 = 1'b1;
        end else if (i_req_1) begin
            w_sel_1 = 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_gnt_0    <= 1'b0;
            r_gnt_1    <= 1'b0;
            r_favour   <= 1'b0;
            r_favour_1 <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_1   <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_0) begin
                        r_state  <= ST_GNT0;
                        r_gnt_0  <= 1'b1;
                        r_favour <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_1 <= 1'b0;
`endif
                    end else if (w_sel_1) begin
                        r_state  <= ST_GNT1;
                        r_gnt_1  <= 1'b1;
                        r_favour <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_1 <= 1'b1;
`endif
                    end
                end
                ST_GNT0: begin
                    if (!i_req_0 || w_limit) begin
                        r_state <= ST_IDLE;
                        r_gnt_0 <= 1'b0;
                        if (w_limit) begin
                            r_favour   <= 1'b1;
                            r_favour_1 <= 1'b1;
                        end
                    end
                end
                ST_GNT1: begin
                    if (!i_req_1 || w_limit) begin
                        r_state <= ST_IDLE;
                        r_gnt_1 <= 1'b0;
                        if (w_limit) begin
                            r_favour   <= 1'b1;
                            r_favour_1 <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt_0 <= 1'b0;
                    r_gnt_1 <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt_0 = r_gnt_0;
    assign o_gnt_1 = r_gnt_1;

endmodule

// File: tb/tb_arbiter_2req.sv
// Scoreboard bench: one unlimited-hold and one HOLD_LIMIT=3 arbiter driven by the same requests.
module tb_arbiter_2req;

    localparam logic [1:0] N  = 2'b00;
    localparam logic [1:0] G0 = 2'b10;
    localparam logic [1:0] G1 = 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [1:0] TIE2 = G1;
`else
    localparam logic [1:0] TIE2 = G0;
`endif

    typedef struct {
        logic [1:0] e_h0;
        logic [1:0] e_h3;
        int         id;
    } exp_t;

    logic clk;
    logic rst;
    logic req_0;
    logic req_1;
    logic h0_gnt_0, h0_gnt_1;
    logic h3_gnt_0, h3_gnt_1;

    exp_t q[$];
    int   n_cmp;
    int   n_err;
    int   step_no;
    bit   done;

    arbiter_2req #(.HOLD_LIMIT(0)) u_dut_h0 (
        .i_clock (clk),
        .i_reset (rst),
        .i_req_0 (req_0),
        .i_req_1 (req_1),
        .o_gnt_0 (h0_gnt_0),
        .o_gnt_1 (h0_gnt_1)
    );

    arbiter_2req #(.HOLD_LIMIT(3)) u_dut_h3 (
        .i_clock (clk),
        .i_reset (rst),
        .i_req_0 (req_0),
        .i_req_1 (req_1),
        .o_gnt_0 (h3_gnt_0),
        .o_gnt_1 (h3_gnt_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [1:0] act, input logic [1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s step %0d: got gnt{0,1}=%b want %b", name, id, act, want);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; queue the grants expected after the next rising edge.
    task automatic step(input logic r, input logic a0, input logic a1,
                        input logic [1:0] e_h0, input logic [1:0] e_h3);
        exp_t e;
        @(negedge clk);
        rst   = r;
        req_0 = a0;
        req_1 = a1;
        step_no++;
        e.e_h0 = e_h0;
        e.e_h3 = e_h3;
        e.id   = step_no;
        q.push_back(e);
        if (r) begin
            #1;
            chk("h0_async_rst", step_no, {h0_gnt_0, h0_gnt_1}, N);
            chk("h3_async_rst", step_no, {h3_gnt_0, h3_gnt_1}, N);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("h0_grant", e.id, {h0_gnt_0, h0_gnt_1}, e.e_h0);
                chk("h3_grant", e.id, {h3_gnt_0, h3_gnt_1}, e.e_h3);
            end
        end
    end

    initial begin : stim
        n_cmp = 0; n_err = 0; step_no = 0; done = 1'b0;
        rst = 1'b0; req_0 = 1'b0; req_1 = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("h0_rst_t0", 0, {h0_gnt_0, h0_gnt_1}, N);
        chk("h3_rst_t0", 0, {h3_gnt_0, h3_gnt_1}, N);

        // Reset held two cycles, then released with no requests.
        step(1, 0, 0, N, N);
        step(1, 0, 0, N, N);
        step(0, 0, 0, N, N);
        step(0, 0, 0, N, N);

        // Single requester: one-edge latency, held grant, one-edge release.
        for (int i = 0; i < 5; i++) step(0, 1, 0, G0, G0);
        step(0, 0, 0, N, N);
        step(0, 0, 0, N, N);

        // Tie from a fresh reset goes to agent 0; release passes through IDLE.
        step(1, 0, 0, N, N);
        step(0, 0, 0, N, N);
        step(0, 1, 1, G0, G0);
        step(0, 1, 1, G0, G0);
        step(0, 0, 1, N, N);
        step(0, 0, 1, G1, G1);

        // Agent 1 holds while agent 0 waits: limit 3 forces a release and favours agent 0.
        step(0, 1, 1, G1, G1);
        step(0, 1, 1, G1, G1);
        step(0, 1, 1, G1, N);
        step(0, 1, 1, G1, G0);
        step(0, 1, 0, N, G0);
        step(0, 1, 0, G0, G0);
        step(0, 0, 0, N, N);
        step(0, 0, 0, N, N);

        // Agent 0 holds, agent 1 waits: 3 contended cycles, IDLE, then favoured agent 1.
        step(0, 1, 0, G0, G0);
        step(0, 1, 1, G0, G0);
        step(0, 1, 1, G0, G0);
        step(0, 1, 1, G0, N);
        step(0, 1, 1, G0, G1);
        step(0, 1, 1, G0, G1);
        step(0, 0, 1, N, G1);
        step(0, 0, 0, N, N);

        // Repeated ties from IDLE, then reset in the middle of a grant.
        step(1, 0, 0, N, N);
        step(0, 0, 0, N, N);
        step(0, 1, 1, G0, G0);
        step(0, 0, 0, N, N);
        step(0, 1, 1, TIE2, TIE2);
        step(0, 0, 0, N, N);
        step(0, 1, 1, G0, G0);
        step(0, 0, 0, N, N);
        step(0, 1, 1, TIE2, TIE2);
        step(0, 1, 1, TIE2, TIE2);
        step(1, 1, 1, N, N);
        step(0, 1, 1, G0, G0);
        step(0, 0, 0, N, N);

        @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations want 0", q.size());
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #50000;
        if (!done) begin
            n_err++;
            $display("FAIL timeout: got no completion want completion by 50000");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

endmodule
